// File: rtl/alu_pkg.sv
// Shared constants, ALU opcode encodings and the writeback entry layout
// for the execute/writeback boundary.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 5;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_NOT = 4'b0101,
    OP_SLA = 4'b0110,
    OP_SRA = 4'b0111,
    OP_SRL = 4'b1000
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              zero;
    logic              carry;
    logic [RD_W-1:0]   rd;
    logic              wr_en;
    logic              set_flags;
  } wb_entry_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry skid buffer between the ALU and writeback, with valid/ready on
// both sides; exposes per-entry destination info for hazard detection.
module wb_skid_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  wb_entry_t            in_entry_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output wb_entry_t            head_o,
  output logic                 pop_o,
  output logic [1:0]           ent_wr_o,
  output logic [1:0][RD_W-1:0] ent_rd_o
);

  logic [1:0] count_q, count_d;
  logic       head_q, head_d;
  logic       tail_q, tail_d;
  wb_entry_t  mem_q [2];
  logic       push;
  logic [1:0] ent_vld;

  assign in_ready_o  = (count_q < 2'(DEPTH));
  assign out_valid_o = (count_q != 2'd0);

  // Flush suppresses both handshakes, so neither the storage nor the
  // flag logic downstream sees a transfer on that edge.
  assign push  = in_valid_i & in_ready_o & ~flush_i;
  assign pop_o = out_valid_o & out_ready_i & ~flush_i;

  assign head_o = mem_q[head_q];

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      count_d = '0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end else begin
      if (push)  tail_d = ~tail_q;
      if (pop_o) head_d = ~head_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop_o};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (push) mem_q[tail_q] <= in_entry_i;
    end
  end

  assign ent_vld[0] = (count_q == 2'd2) | ((count_q == 2'd1) & ~head_q);
  assign ent_vld[1] = (count_q == 2'd2) | ((count_q == 2'd1) &  head_q);

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      ent_wr_o[i] = ent_vld[i] & mem_q[i].wr_en;
      ent_rd_o[i] = mem_q[i].rd;
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: buffers ALU results, gates r0 writes,
// commits Z/C flags in retire order and reports RAW hazards to decode.
module alu_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_res,
  input  logic              in_zero,
  input  logic              in_carry,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wr_en,
  input  logic              in_set_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wr_en,
  output logic              flag_z,
  output logic              flag_c,
  input  logic [RD_W-1:0]   chk_rs1,
  input  logic [RD_W-1:0]   chk_rs2,
  output logic              hazard
);

  import alu_pkg::*;

  wb_entry_t            in_entry;
  wb_entry_t            head;
  logic                 pop;
  logic [1:0]           ent_wr;
  logic [1:0][RD_W-1:0] ent_rd;
  logic                 flag_z_q, flag_c_q;

  assign in_entry = '{res: in_res, zero: in_zero, carry: in_carry, rd: in_rd,
                      wr_en: in_wr_en, set_flags: in_set_flags};

  wb_skid_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_entry_i  (in_entry),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .head_o      (head),
    .pop_o       (pop),
    .ent_wr_o    (ent_wr),
    .ent_rd_o    (ent_rd)
  );

  assign out_data  = out_valid ? head.res : '0;
  assign out_rd    = out_valid ? head.rd  : '0;
  assign out_wr_en = out_valid & head.wr_en & (head.rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else if (pop && head.set_flags) begin
      flag_z_q <= head.zero;
      flag_c_q <= head.carry;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;

  // r0 writes never produce a hazard since the register reads as zero.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (ent_wr[i] && (ent_rd[i] != '0) &&
          ((ent_rd[i] == chk_rs1) || (ent_rd[i] == chk_rs2)))
        hazard = 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed and randomized checks of alu_wb_stage against a queue-based model.
module tb_alu_wb_stage;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic [4:0]  rd;
    logic        wr;
    logic        sf;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] in_res;
  logic        in_zero, in_carry;
  logic [4:0]  in_rd;
  logic        in_wr_en, in_set_flags;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wr_en, flag_z, flag_c;
  logic [4:0]  chk_rs1, chk_rs2;
  logic        hazard;

  int   checks   = 0;
  int   failures = 0;
  ent_t mq[$];
  logic mz, mc;

  always #5 clk = ~clk;

  alu_wb_stage #(.DATA_W(32), .RD_W(5), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res),
    .in_zero(in_zero), .in_carry(in_carry), .in_rd(in_rd),
    .in_wr_en(in_wr_en), .in_set_flags(in_set_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_wr_en(out_wr_en), .flag_z(flag_z), .flag_c(flag_c),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic e_haz;
    bit   nonempty;
    nonempty = (mq.size() > 0);
    e_haz = 1'b0;
    foreach (mq[i])
      if (mq[i].wr && mq[i].rd != 5'd0 && (mq[i].rd == chk_rs1 || mq[i].rd == chk_rs2))
        e_haz = 1'b1;
    chk({tag, ".in_ready"},  in_ready,  32'(mq.size() < 2));
    chk({tag, ".out_valid"}, out_valid, 32'(nonempty));
    chk({tag, ".out_data"},  out_data,  nonempty ? mq[0].res : 32'd0);
    chk({tag, ".out_rd"},    out_rd,    nonempty ? 32'(mq[0].rd) : 32'd0);
    chk({tag, ".out_wr_en"}, out_wr_en, 32'(nonempty && mq[0].wr && mq[0].rd != 5'd0));
    chk({tag, ".flag_z"},    flag_z,    32'(mz));
    chk({tag, ".flag_c"},    flag_c,    32'(mc));
    chk({tag, ".hazard"},    hazard,    32'(e_haz));
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic z, input logic c,
                       input logic [4:0] rd, input logic wr, input logic sf);
    in_valid = v; in_res = r; in_zero = z; in_carry = c;
    in_rd = rd; in_wr_en = wr; in_set_flags = sf;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    ent_t e;
    bit   do_push, do_pop;
    if (flush) begin
      mq.delete();
    end else begin
      do_push = in_valid && (mq.size() < 2);
      do_pop  = (mq.size() > 0) && out_ready;
      if (do_pop) begin
        if (mq[0].sf) begin mz = mq[0].z; mc = mq[0].c; end
        mq.delete(0);
      end
      if (do_push) begin
        e.res = in_res; e.z = in_zero; e.c = in_carry;
        e.rd = in_rd; e.wr = in_wr_en; e.sf = in_set_flags;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    chk_rs1 = '0; chk_rs2 = '0;
    drive(0, 0, 0, 0, 0, 0, 0);
    mz = 1'b0; mc = 1'b0;
    #12;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_reset");

    // ADD 30+10 -> 40 into r3
    out_ready = 1'b1;
    drive(1, 32'd40, 0, 0, 5'd3, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("add.data", out_data, 32'd40);
    check_all("add.out");
    tick();
    check_all("add.empty");

    // Backpressure
    out_ready = 1'b0;
    drive(1, 32'd40, 0, 0, 5'd3, 1, 0); tick();
    drive(1, 32'd20, 0, 0, 5'd4, 1, 0); tick();
    chk("bp.in_ready_full", in_ready, 32'd0);
    check_all("bp.full");
    drive(1, 32'd99, 0, 0, 5'd5, 1, 0); tick();
    check_all("bp.ignored");
    drive(0, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    #1;
    chk("bp.first", out_data, 32'd40);
    tick();
    chk("bp.second", out_data, 32'd20);
    tick();
    chk("bp.in_ready_again", in_ready, 32'd1);
    check_all("bp.drained");

    // Flags commit at pop, not push
    out_ready = 1'b0;
    drive(1, 32'd0, 1, 1, 5'd1, 1, 1); tick();
    chk("flags.no_push_update", flag_z, 32'd0);
    drive(1, 32'd17, 0, 0, 5'd2, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    #1;
    tick();
    chk("flags.z_first_pop", flag_z, 32'd1);
    chk("flags.c_first_pop", flag_c, 32'd1);
    tick();
    chk("flags.z_second_pop", flag_z, 32'd1);
    check_all("flags.end");

    // r0 gating and hazard
    out_ready = 1'b0;
    drive(1, 32'd5, 0, 0, 5'd0, 1, 0); tick();
    chk("r0.wr_en", out_wr_en, 32'd0);
    chk("r0.hazard", hazard, 32'd0);
    drive(1, 32'd9, 0, 0, 5'd7, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_rs2 = 5'd7;
    #1;
    chk("haz.rd7", hazard, 32'd1);
    out_ready = 1'b1;
    tick();
    check_all("haz.head7");
    tick();
    chk("haz.cleared", hazard, 32'd0);
    check_all("haz.end");
    chk_rs2 = 5'd0;

    // Flush beats same-cycle push and pop
    out_ready = 1'b0;
    drive(1, 32'h11, 0, 0, 5'd8, 1, 1); tick();
    drive(1, 32'h22, 0, 0, 5'd9, 1, 0); tick();
    flush = 1'b1; out_ready = 1'b1;
    drive(1, 32'hAA, 0, 0, 5'd10, 1, 0);
    tick();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("flush.out_valid", out_valid, 32'd0);
    chk("flush.flag_z", flag_z, 32'd1);
    chk("flush.flag_c", flag_c, 32'd1);
    check_all("flush.end");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
            5'($urandom_range(0, 7)), $urandom_range(0, 1), $urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      chk_rs1   = 5'($urandom_range(0, 7));
      chk_rs2   = 5'($urandom_range(0, 7));
      #1;
      check_all("rand");
      tick();
    end
    flush = 1'b0;

    // Asynchronous reset with an entry buffered and flag_z set
    out_ready = 1'b0;
    drive(1, 32'h5, 1, 0, 5'd2, 1, 1); tick();
    drive(1, 32'h6, 0, 0, 5'd3, 1, 0); tick();
    if (mq.size() == 2 && mq[0].res == 32'h5) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      out_ready = 1'b1; tick();
      out_ready = 1'b0;
      #1;
      chk("rst.pre_flag_z", flag_z, 32'd1);
      chk("rst.pre_valid", out_valid, 32'd1);
    end else begin
      check_all("rst.setup");
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    mq.delete(); mz = 1'b0; mc = 1'b0;
    chk("rst.async_valid", out_valid, 32'd0);
    chk("rst.async_data", out_data, 32'd0);
    chk("rst.async_flag_z", flag_z, 32'd0);
    check_all("rst.async");
    #2;
    rst_n = 1'b1;
    tick();
    check_all("rst.released");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
